count_seq_decoder: RTL and testbench
====================================

COUNT_SEQ_DECODER -- requirements
Module: count_seq_decoder

Interface
REQ-001 SHALL have parameter N, default 10: modulus of the observed up/down count sequence; legal values are 0..N-1.
REQ-002 SHALL have parameter WIDTH, default derived from N: 1 if N<2, 2 if N<4, 3 if N<8, 4 if N<16, 5 if N<32, 6 if N<64, 7 if N<128, 8 if N<256, else 16.
REQ-003 SHALL have port i_clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port i_valid, input, 1, i_q carries a new sample this cycle.
REQ-006 SHALL have port i_q, input, WIDTH, sampled count value.
REQ-007 SHALL have port o_locked, output, 1, a legal step has been seen since the last reset or error.
REQ-008 SHALL have port o_dir, output, 2, last classified step: 00 hold, 01 up, 10 down; 11 never driven.
REQ-009 SHALL have port o_wrap, output, 1, one-cycle pulse on a legal wrap step.
REQ-010 SHALL have port o_err, output, 1, one-cycle pulse on an illegal or out-of-range sample.
REQ-011 SHALL have port o_wrap_cnt, output, 16, number of wraps detected, modulo 2^16.
REQ-012 SHALL have port o_err_cnt, output, 8, number of errors, saturating at 255.

Function
REQ-013 SHALL register all outputs; the response to a valid sample SHALL appear in the cycle after i_valid is sampled high.
REQ-014 SHALL ignore i_q when i_valid=0, hold o_dir, o_locked and both counters, and drive o_wrap=o_err=0.
REQ-015 SHALL implement three states: IDLE (no reference), ACQ (reference held, unlocked) and TRACK (locked).
REQ-016 IDLE: an in-range sample (i_q<N) SHALL become the reference and move the state to ACQ; an out-of-range sample SHALL pulse o_err and keep the state in IDLE.
REQ-017 ACQ/TRACK: each valid sample SHALL be classified against the reference prev in this priority order:
REQ-018 - i_q>=N: out-of-range error.
REQ-019 - i_q==prev: hold.
REQ-020 - prev<N-1 and i_q==prev+1: up; prev==N-1 and i_q==0: up with wrap.
REQ-021 - prev>0 and i_q==prev-1: down; prev==0 and i_q==N-1: down with wrap.
REQ-022 - anything else: step error.
REQ-023 When up and down-with-wrap coincide (N=2), the step SHALL be classified up.
REQ-024 For N=1, every in-range sample SHALL classify as hold.
REQ-025 A legal step SHALL update o_dir, set o_locked=1, move the state to TRACK and make i_q the new reference.
REQ-026 A wrap step SHALL also pulse o_wrap and increment o_wrap_cnt, rolling over from 65535 to 0.
REQ-027 A step error SHALL pulse o_err, increment o_err_cnt (saturating), clear o_locked, set o_dir=00, make i_q the new reference and move the state to ACQ.
REQ-028 An out-of-range error in ACQ or TRACK SHALL pulse o_err, increment o_err_cnt (saturating), clear o_locked, set o_dir=00, keep the existing reference and move the state to ACQ.
REQ-029 All comparisons and increments SHALL be performed at WIDTH+1 bits so that prev+1 cannot alias at 2^WIDTH-1.

Reset
REQ-030 SHALL, while i_rst=1, asynchronously force: state IDLE, reference 0, o_locked=0, o_dir=00, o_wrap=0, o_err=0, o_wrap_cnt=0, o_err_cnt=0.
REQ-031 A reset asserted mid-sequence SHALL discard the reference; the first valid sample after release SHALL be treated as an IDLE sample.

Verification
REQ-032 N=10, valid samples 0,1,2,...,9,0,1 -> o_dir=01 from the second sample onward, o_locked=1; one o_wrap pulse after the 9->0 step; o_wrap_cnt=1.
REQ-033 N=10, valid samples 3,2,1,0,9,8 -> o_dir=10, o_wrap pulse after the 0->9 step, o_err=0 throughout.
REQ-034 N=10, valid samples 4,5,5,4 -> o_dir sequence 01,00,10; no errors.
REQ-035 N=10, valid samples 4,5,7,8 -> o_err pulse after 7 with o_locked=0 and o_err_cnt=1; after 8, o_dir=01 and o_locked=1.
REQ-036 N=10, sample 12 in IDLE, then 300 further illegal jumps -> o_err_cnt saturates at 255; state stays IDLE after 12.
REQ-037 N=2, samples 0,1,0 -> first step classified up (no wrap), second classified up with wrap; i_rst pulse mid-stream -> all outputs 0 and the next sample is re-acquired.

Source files
------------

// File: rtl/count_seq_decoder.sv
// Up/down count-sequence decoder.
// Watches a sampled modulo-N counter value and classifies each new sample
// against the previous one as hold, up or down (with wrap detection). It flags
// illegal jumps and out-of-range values. The sample is compared with a reference
// held in an IDLE / ACQ / TRACK state machine.
module count_seq_decoder #(
    parameter int N     = 10,
    parameter int WIDTH = (N < 2)   ? 1 :
                          (N < 4)   ? 2 :
                          (N < 8)   ? 3 :
                          (N < 16)  ? 4 :
                          (N < 32)  ? 5 :
                          (N < 64)  ? 6 :
                          (N < 128) ? 7 :
                          (N < 256) ? 8 : 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_q,
    output logic             o_locked,
    output logic [1:0]       o_dir,
    output logic             o_wrap,
    output logic             o_err,
    output logic [15:0]      o_wrap_cnt,
    output logic [7:0]       o_err_cnt
);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    typedef enum logic [2:0] {
        C_RANGE, C_HOLD, C_UP, C_UP_WRAP, C_DOWN, C_DOWN_WRAP, C_STEP
    } step_t;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // One extra bit keeps prev+1 from aliasing back to 0 at 2^WIDTH-1.
    localparam logic [WIDTH:0] N_W    = (WIDTH+1)'(N);
    localparam logic [WIDTH:0] N_M1_W = (WIDTH+1)'(N - 1);
    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] ZERO_W = '0;

    state_t             state, state_nxt;
    step_t              cls;
    logic [WIDTH-1:0]   prev, prev_nxt;
    logic [WIDTH:0]     q_w, prev_w;

    logic               locked_nxt;
    logic [1:0]         dir_nxt;
    logic               wrap_nxt;
    logic               err_nxt;
    logic [15:0]        wrap_cnt_nxt;
    logic [7:0]         err_cnt_nxt;

    assign q_w    = {1'b0, i_q};
    assign prev_w = {1'b0, prev};

    // State, reference and registered outputs; async reset clears all of them.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // the comb blocks below use = because they describe pure logic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            prev       <= '0;
            o_locked   <= 1'b0;
            o_dir      <= DIR_HOLD;
            o_wrap     <= 1'b0;
            o_err      <= 1'b0;
            o_wrap_cnt <= '0;
            o_err_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            o_locked   <= locked_nxt;
            o_dir      <= dir_nxt;
            o_wrap     <= wrap_nxt;
            o_err      <= err_nxt;
            o_wrap_cnt <= wrap_cnt_nxt;
            o_err_cnt  <= err_cnt_nxt;
        end
    end

    // Classify the sample against the reference and pick the next state.
    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        cls       = C_STEP;
        state_nxt = state;

        // Priority order matters: up is checked before down so that, for N=2,
        // 0->1 reads as up rather than down-with-wrap.
        if (q_w >= N_W)
            cls = C_RANGE;
        else if (q_w == prev_w)
            cls = C_HOLD;
        else if ((prev_w < N_M1_W) && (q_w == prev_w + ONE_W))
            cls = C_UP;
        else if ((prev_w == N_M1_W) && (q_w == ZERO_W))
            cls = C_UP_WRAP;
        else if ((prev_w > ZERO_W) && (q_w == prev_w - ONE_W))
            cls = C_DOWN;
        else if ((prev_w == ZERO_W) && (q_w == N_M1_W))
            cls = C_DOWN_WRAP;

        if (i_valid) begin
            case (state)
                IDLE:    state_nxt = (cls == C_RANGE) ? IDLE : ACQ;
                default: state_nxt = (cls == C_RANGE || cls == C_STEP) ? ACQ : TRACK;
            endcase
        end
    end

    // Next values of the reference and the registered outputs.
    always_comb begin
        prev_nxt     = prev;
        locked_nxt   = o_locked;
        dir_nxt      = o_dir;
        wrap_nxt     = 1'b0;
        err_nxt      = 1'b0;
        wrap_cnt_nxt = o_wrap_cnt;
        err_cnt_nxt  = o_err_cnt;

        if (i_valid) begin
            if (cls == C_RANGE || (state != IDLE && cls == C_STEP)) begin
                // A step error re-seeds the reference. An out-of-range value
                // never becomes the reference, so the old reference is kept.
                err_nxt     = 1'b1;
                err_cnt_nxt = (o_err_cnt == 8'hFF) ? o_err_cnt : o_err_cnt + 8'd1;
                if (state != IDLE) begin
                    locked_nxt = 1'b0;
                    dir_nxt    = DIR_HOLD;
                end
                if (cls == C_STEP)
                    prev_nxt = i_q;
            end else if (state == IDLE) begin
                prev_nxt = i_q;
            end else begin
                prev_nxt   = i_q;
                locked_nxt = 1'b1;
                case (cls)
                    C_UP, C_UP_WRAP:     dir_nxt = DIR_UP;
                    C_DOWN, C_DOWN_WRAP: dir_nxt = DIR_DOWN;
                    default:             dir_nxt = DIR_HOLD;
                endcase
                if (cls == C_UP_WRAP || cls == C_DOWN_WRAP) begin
                    wrap_nxt     = 1'b1;
                    wrap_cnt_nxt = o_wrap_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_count_seq_decoder.sv
// Directed bench for count_seq_decoder. It drives one DUT with N=10 and one
// with N=2. Expected output words are queued as each sample is driven and
// checked one clock later.
module tb_count_seq_decoder;

    typedef struct packed {
        logic        locked;
        logic [1:0]  dir;
        logic        wrap;
        logic        err;
        logic [15:0] wrap_cnt;
        logic [7:0]  err_cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid10 = 1'b0, valid2 = 1'b0;
    logic [3:0]  q10 = '0;
    logic [1:0]  q2  = '0;

    logic        locked10, wrap10, err10, locked2, wrap2, err2;
    logic [1:0]  dir10, dir2;
    logic [15:0] wrap_cnt10, wrap_cnt2;
    logic [7:0]  err_cnt10, err_cnt2;

    int vectors = 0;
    int miscompares = 0;

    // Running expected counters, advanced from the expected pulse flags.
    int exp_wc10 = 0, exp_ec10 = 0, exp_wc2 = 0, exp_ec2 = 0;

    obs_t sb10[$];
    obs_t sb2[$];

    count_seq_decoder #(.N(10)) dut10 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid10), .i_q(q10),
        .o_locked(locked10), .o_dir(dir10), .o_wrap(wrap10), .o_err(err10),
        .o_wrap_cnt(wrap_cnt10), .o_err_cnt(err_cnt10)
    );

    count_seq_decoder #(.N(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid2), .i_q(q2),
        .o_locked(locked2), .o_dir(dir2), .o_wrap(wrap2), .o_err(err2),
        .o_wrap_cnt(wrap_cnt2), .o_err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    function automatic obs_t obs10();
        return '{locked10, dir10, wrap10, err10, wrap_cnt10, err_cnt10};
    endfunction

    function automatic obs_t obs2();
        return '{locked2, dir2, wrap2, err2, wrap_cnt2, err_cnt2};
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Pulse reset asynchronously away from the clock edge and check that all
    // outputs of both DUTs clear before any clock edge arrives.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        check({tag, "_rst10"}, obs10(), '0);
        check({tag, "_rst2"},  obs2(),  '0);
        exp_wc10 = 0; exp_ec10 = 0; exp_wc2 = 0; exp_ec2 = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step10(input string tag, input bit v, input logic [3:0] q,
                          input bit lk, input logic [1:0] dir,
                          input bit w, input bit e);
        obs_t exp, got;
        if (w) exp_wc10 = (exp_wc10 + 1) % 65536;
        if (e && exp_ec10 < 255) exp_ec10++;
        sb10.push_back('{lk, dir, w, e, 16'(exp_wc10), 8'(exp_ec10)});
        valid10 = v;
        q10     = q;
        @(posedge clk);
        #1;
        got = obs10();
        if (sb10.size() == 0) begin
            check({tag, "_empty"}, got, ~got);
        end else begin
            exp = sb10.pop_front();
            check(tag, got, exp);
        end
        valid10 = 1'b0;
    endtask

    task automatic step2(input string tag, input logic [1:0] q,
                         input bit lk, input logic [1:0] dir,
                         input bit w, input bit e);
        obs_t exp, got;
        if (w) exp_wc2 = (exp_wc2 + 1) % 65536;
        if (e && exp_ec2 < 255) exp_ec2++;
        sb2.push_back('{lk, dir, w, e, 16'(exp_wc2), 8'(exp_ec2)});
        valid2 = 1'b1;
        q2     = q;
        @(posedge clk);
        #1;
        got = obs2();
        if (sb2.size() == 0) begin
            check({tag, "_empty"}, got, ~got);
        end else begin
            exp = sb2.pop_front();
            check(tag, got, exp);
        end
        valid2 = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset("init");

        // Full up count with a 9->0 wrap, then a stalled (invalid) cycle.
        step10("up_first", 1, 4'd0, 0, 2'b00, 0, 0);
        for (int i = 1; i <= 9; i++)
            step10("up_run", 1, 4'(i), 1, 2'b01, 0, 0);
        step10("up_wrap", 1, 4'd0, 1, 2'b01, 1, 0);
        step10("up_after", 1, 4'd1, 1, 2'b01, 0, 0);
        step10("invalid_hold", 0, 4'd7, 1, 2'b01, 0, 0);

        // Down count with a 0->9 wrap.
        do_reset("down");
        step10("dn_first", 1, 4'd3, 0, 2'b00, 0, 0);
        step10("dn_2", 1, 4'd2, 1, 2'b10, 0, 0);
        step10("dn_1", 1, 4'd1, 1, 2'b10, 0, 0);
        step10("dn_0", 1, 4'd0, 1, 2'b10, 0, 0);
        step10("dn_wrap", 1, 4'd9, 1, 2'b10, 1, 0);
        step10("dn_8", 1, 4'd8, 1, 2'b10, 0, 0);

        // Up, hold, down.
        do_reset("hold");
        step10("hd_4", 1, 4'd4, 0, 2'b00, 0, 0);
        step10("hd_5", 1, 4'd5, 1, 2'b01, 0, 0);
        step10("hd_5h", 1, 4'd5, 1, 2'b00, 0, 0);
        step10("hd_4d", 1, 4'd4, 1, 2'b10, 0, 0);

        // Step error re-seeds the reference. Out-of-range keeps the reference.
        do_reset("stepe");
        step10("se_4", 1, 4'd4, 0, 2'b00, 0, 0);
        step10("se_5", 1, 4'd5, 1, 2'b01, 0, 0);
        step10("se_7", 1, 4'd7, 0, 2'b00, 0, 1);
        step10("se_8", 1, 4'd8, 1, 2'b01, 0, 0);
        step10("se_oor", 1, 4'd15, 0, 2'b00, 0, 1);
        step10("se_9", 1, 4'd9, 1, 2'b01, 0, 0);

        // Out-of-range in IDLE stays IDLE. Then saturate the error counter.
        do_reset("sat");
        step10("sat_12", 1, 4'd12, 0, 2'b00, 0, 1);
        step10("sat_acq", 1, 4'd0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 300; i++)
            step10("sat_jump", 1, (i % 2 == 0) ? 4'd5 : 4'd0, 0, 2'b00, 0, 1);

        // N=2: up, then up with wrap, then reset mid-stream and re-acquire.
        do_reset("n2");
        step2("n2_0", 2'd0, 0, 2'b00, 0, 0);
        step2("n2_up", 2'd1, 1, 2'b01, 0, 0);
        step2("n2_wrap", 2'd0, 1, 2'b01, 1, 0);
        do_reset("n2_mid");
        step2("n2_reacq", 2'd1, 0, 2'b00, 0, 0);
        step2("n2_wrap2", 2'd0, 1, 2'b01, 1, 0);
        step2("n2_oor", 2'd3, 0, 2'b00, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
